// File: rtl/mem_sram_responder.sv
// mem_sram_responder: memory-side slave for the request/grant/rvalid protocol.
// Granted requests access an on-chip word array at the grant edge; responses
// return in grant order exactly LATENCY cycles later, with a cap on the number
// of granted-but-unanswered transactions and an external stall input.
module mem_sram_responder #(
    parameter int ADDRESS_SIZE    = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int NUM_WORDS       = 1024,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDRESS_SIZE-1:0]   address_i,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i,
    input  logic                      data_req_i,
    input  logic                      data_we_i,
    input  logic [DATA_WIDTH/8-1:0]   data_be_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    output logic [DATA_WIDTH-1:0]     data_rdata_o,
    output logic                      data_err_o,
    input  logic                      stall_i
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BE_W);
    localparam int IDX   = $clog2(NUM_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    // Address decode: word index from the bits above the byte offset; any set
    // bit above the array range makes the request an error response.
    logic [IDX-1:0] word_idx;
    logic           in_range;

    assign word_idx = address_i[OFF +: IDX];
    assign in_range = (address_i >> (OFF + IDX)) == '0;

    // Word array. Stage 0 of the response pipeline samples it at the grant edge.
    logic [DATA_WIDTH-1:0] mem_array [NUM_WORDS];

    // Response pipeline, one entry per cycle of latency; the last entry drives the outputs.
    logic [LATENCY-1:0]                 vld_q,   vld_d;
    logic [LATENCY-1:0]                 err_q,   err_d;
    logic [LATENCY-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]                   inflight_q, inflight_d;

    assign data_rvalid_o = vld_q[LATENCY-1];
    assign data_err_o    = err_q[LATENCY-1];
    assign data_rdata_o  = rdata_q[LATENCY-1];

    // A slot is available if below the cap, or if the oldest response retires this cycle.
    assign data_gnt_o = data_req_i & ~stall_i & ~rst_i &
                        ((inflight_q < MAX_CNT) | data_rvalid_o);

    // Next state of the response pipeline and of the outstanding counter.
    always_comb begin
        // NOTE: every signal gets a default before any conditional update, so
        // no path leaves a value unassigned and no latch is inferred.
        vld_d      = '0;
        err_d      = '0;
        rdata_d    = '0;
        inflight_d = inflight_q;

        vld_d[0]   = data_gnt_o;
        err_d[0]   = data_gnt_o & ~in_range;
        rdata_d[0] = (data_gnt_o & ~data_we_i & in_range) ? mem_array[word_idx] : '0;

        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            err_d[i]   = err_q[i-1];
            rdata_d[i] = rdata_q[i-1];
        end

        case ({data_gnt_o, data_rvalid_o})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Byte-masked array write at the grant edge; out-of-range writes are dropped.
    // NOTE: the array has no reset; its contents survive rst_i so writes
    // committed before a reset remain readable afterwards.
    always_ff @(posedge clk_i) begin
        if (data_gnt_o && data_we_i && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (data_be_i[b]) begin
                    mem_array[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Pipeline and counter registers; reset discards every in-flight response.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge value regardless of statement order.
        if (rst_i) begin
            vld_q      <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
            inflight_q <= '0;
        end else begin
            vld_q      <= vld_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_mem_sram_responder.sv
// Testbench for mem_sram_responder: table-driven single transactions, a
// cycle-accurate scoreboard on the main instance, and hand-written sequences
// for back-to-back, outstanding-cap, stall and reset corner cases.
module tb_mem_sram_responder;

    localparam int L  = 2;
    localparam int MO = 2;

    logic        clk;
    logic        rst;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        req;
    logic        we;
    logic [7:0]  be;
    logic        stall;

    logic        gnt,   rvalid, err;
    logic [63:0] rdata;
    logic        gnt_a, rv_a, err_a;
    logic [63:0] rd_a;
    logic        gnt_b, rv_b, err_b;
    logic [63:0] rd_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mem_sram_responder dut (
        .clk_i(clk), .rst_i(rst), .address_i(addr), .data_wdata_i(wdata),
        .data_req_i(req), .data_we_i(we), .data_be_i(be), .data_gnt_o(gnt),
        .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err), .stall_i(stall)
    );

    mem_sram_responder #(.LATENCY(3), .MAX_OUTSTANDING(2)) u_l3m2 (
        .clk_i(clk), .rst_i(rst), .address_i(addr), .data_wdata_i(wdata),
        .data_req_i(req), .data_we_i(we), .data_be_i(be), .data_gnt_o(gnt_a),
        .data_rvalid_o(rv_a), .data_rdata_o(rd_a), .data_err_o(err_a), .stall_i(stall)
    );

    mem_sram_responder #(.LATENCY(3), .MAX_OUTSTANDING(3)) u_l3m3 (
        .clk_i(clk), .rst_i(rst), .address_i(addr), .data_wdata_i(wdata),
        .data_req_i(req), .data_we_i(we), .data_be_i(be), .data_gnt_o(gnt_b),
        .data_rvalid_o(rv_b), .data_rdata_o(rd_b), .data_err_o(err_b), .stall_i(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard on the main instance ----------------
    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          due;
    } resp_t;

    resp_t       sb_q[$];
    resp_t       sb_item;
    logic [63:0] model_mem [1024];
    logic        exp_rv, exp_gnt, m_in;
    logic [9:0]  m_idx;

    always @(negedge clk) begin
        exp_rv  = (sb_q.size() != 0) && (sb_q[0].due == cyc);
        exp_gnt = req & ~stall & ~rst & ((sb_q.size() < MO) | exp_rv);
        check("sb_gnt", 64'(gnt), 64'(exp_gnt));
        check("sb_rvalid", 64'(rvalid), 64'(exp_rv));
        if (exp_rv) begin
            sb_item = sb_q.pop_front();
            check("sb_rdata", rdata, sb_item.rdata);
            check("sb_err", 64'(err), 64'(sb_item.err));
        end
        if (req && gnt === 1'b1) begin
            m_in  = (addr >> 13) == 64'd0;
            m_idx = addr[12:3];
            sb_item.err = ~m_in;
            sb_item.due = cyc + L;
            if (we) begin
                sb_item.rdata = 64'd0;
                if (m_in)
                    for (int b = 0; b < 8; b++)
                        if (be[b]) model_mem[m_idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                sb_item.rdata = m_in ? model_mem[m_idx] : 64'd0;
            end
            sb_q.push_back(sb_item);
        end
        if (rst) sb_q.delete();
    end

    // ---------------- stimulus helpers ----------------
    // Idle bus: request low, other request signals deliberately busy.
    task automatic idle_bus();
        req   = 1'b0;
        we    = 1'b1;
        be    = 8'hFF;
        addr  = 64'h10;
        wdata = {$urandom, $urandom};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction on the main instance with an expected response.
    task automatic single(input string name, input logic w, input logic [63:0] a,
                          input logic [63:0] d, input logic [7:0] b,
                          input logic [63:0] exp_rd, input logic exp_err);
        int g;
        bit seen;
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(negedge clk);
        g = cyc;
        check({name, "_gnt"}, 64'(gnt), 64'd1);
        step();
        idle_bus();
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            if (rvalid === 1'b1) begin
                seen = 1'b1;
                check({name, "_lat"}, 64'(cyc - g), 64'(L));
                check({name, "_rdata"}, rdata, exp_rd);
                check({name, "_err"}, 64'(err), 64'(exp_err));
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_rvalid expected=rvalid", name);
        end
        step();
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    logic [5:0]  g2, g3;
    logic [11:0] v2, v3;
    logic [63:0] rq2[$], rq3[$];
    logic [3:0]  rv_hist;
    logic [63:0] rd_hist[4];
    int          out_a, max_a, stall_rv;
    logic        late_rv;

    initial begin
        vecs[0]  = '{"w_full",    1'b1, 64'h10,         64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
        vecs[1]  = '{"r_full",    1'b0, 64'h10,         64'h0,                8'hFF, 64'h1122334455667788, 1'b0};
        vecs[2]  = '{"w_lo",      1'b1, 64'h10,         64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0};
        vecs[3]  = '{"r_lo",      1'b0, 64'h10,         64'h0,                8'hFF, 64'h11223344AAAAAAAA, 1'b0};
        vecs[4]  = '{"w_be0",     1'b1, 64'h10,         64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0, 1'b0};
        vecs[5]  = '{"r_be0_off", 1'b0, 64'h13,         64'h0,                8'h00, 64'h11223344AAAAAAAA, 1'b0};
        vecs[6]  = '{"w_word0",   1'b1, 64'h0,          64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0, 1'b0};
        vecs[7]  = '{"r_msb_oor", 1'b0, 64'h8000000000000000, 64'h0,          8'hFF, 64'h0, 1'b1};
        vecs[8]  = '{"w_oor",     1'b1, 64'h2000,       64'h5555555555555555, 8'hFF, 64'h0, 1'b1};
        vecs[9]  = '{"r_word0",   1'b0, 64'h0,          64'h0,                8'hFF, 64'hDEADBEEFCAFEF00D, 1'b0};
        vecs[10] = '{"w_last",    1'b1, 64'h1FF8,       64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0};
        vecs[11] = '{"w_mix",     1'b1, 64'h10,         64'hBBCCDDEEFF001122, 8'hC3, 64'h0, 1'b0};
        vecs[12] = '{"r_mix",     1'b0, 64'h10,         64'h0,                8'hFF, 64'hBBCC3344AAAA1122, 1'b0};

        rst = 1'b1; stall = 1'b0;
        idle_bus();
        step();
        step();

        // Reset state, with a request present that must not be granted.
        req = 1'b1; we = 1'b0;
        @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_inflight", 64'(dut.inflight_q), 64'd0);
        step();
        rst = 1'b0;
        idle_bus();
        step();

        foreach (vecs[i])
            single(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                   vecs[i].exp_rdata, vecs[i].exp_err);
        single("r_last", 1'b0, 64'h1FF8, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0);

        // Back-to-back write then read of the same word.
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin req = 1'b1; we = 1'b1; addr = 64'h20; wdata = 64'hE0E1E2E3E4E5E6E7; be = 8'hFF; end
            else if (k == 1) begin req = 1'b1; we = 1'b0; be = 8'h00; end
            else idle_bus();
            @(negedge clk);
            if (k < 2) check($sformatf("raw_gnt%0d", k), 64'(gnt), 64'd1);
            rv_hist[k] = rvalid;
            rd_hist[k] = rdata;
            step();
        end
        check("raw_rv_pattern", 64'(rv_hist), 64'b1100);
        check("raw_wr_rdata", rd_hist[2], 64'd0);
        check("raw_rd_rdata", rd_hist[3], 64'hE0E1E2E3E4E5E6E7);

        // Prefill six words for the burst.
        for (int k = 0; k < 6; k++)
            single($sformatf("pre%0d", k), 1'b1, 64'h100 + 64'(8*k),
                   64'hB0B0000000000000 | 64'(k), 8'hFF, 64'h0, 1'b0);
        for (int k = 0; k < 3; k++) step();

        // Burst of reads with request held high for six cycles.
        out_a = 0; max_a = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < 6) begin req = 1'b1; we = 1'b0; addr = 64'h100 + 64'(8*k); be = 8'hFF; end
            else idle_bus();
            @(negedge clk);
            if (k < 6) begin g2[k] = gnt_a; g3[k] = gnt_b; end
            v2[k] = rv_a;
            v3[k] = rv_b;
            if (rv_a) rq2.push_back(rd_a);
            if (rv_b) rq3.push_back(rd_b);
            out_a = out_a + ((req && gnt_a) ? 1 : 0) - (rv_a ? 1 : 0);
            if (out_a > max_a) max_a = out_a;
            step();
        end
        check("l3m2_gnt_pattern", 64'(g2), 64'b011011);
        check("l3m3_gnt_pattern", 64'(g3), 64'b111111);
        check("l3m2_rv_pattern", 64'(v2), 64'h0D8);
        check("l3m3_rv_pattern", 64'(v3), 64'h1F8);
        check("l3m2_max_inflight", 64'(max_a), 64'd2);
        check("l3m2_rv_count", 64'(rq2.size()), 64'd4);
        check("l3m3_rv_count", 64'(rq3.size()), 64'd6);
        for (int k = 0; k < 4 && k < rq2.size(); k++)
            check($sformatf("l3m2_order%0d", k), rq2[k],
                  64'hB0B0000000000000 | 64'((k < 2) ? k : k + 1));
        for (int k = 0; k < 6 && k < rq3.size(); k++)
            check($sformatf("l3m3_order%0d", k), rq3[k], 64'hB0B0000000000000 | 64'(k));
        for (int k = 0; k < 3; k++) step();

        // Stall with two transactions in flight.
        stall_rv = 0;
        for (int k = 0; k < 7; k++) begin
            req = 1'b1; we = 1'b0; be = 8'hFF;
            addr = 64'h100 + 64'(8 * ((k < 2) ? k : 2));
            stall = (k >= 2 && k <= 5);
            @(negedge clk);
            if (k < 2 || k == 6) check($sformatf("stall_gnt%0d", k), 64'(gnt), 64'd1);
            else begin
                check($sformatf("stall_gnt%0d", k), 64'(gnt), 64'd0);
                if (rvalid) stall_rv++;
            end
            step();
        end
        stall = 1'b0;
        idle_bus();
        check("stall_rv_count", 64'(stall_rv), 64'd2);
        for (int k = 0; k < 4; k++) step();

        // Reset one cycle after a read grant.
        single("w_pre_rst", 1'b1, 64'h40, 64'hFEEDFACE01234567, 8'hFF, 64'h0, 1'b0);
        req = 1'b1; we = 1'b0; addr = 64'h40; be = 8'hFF;
        @(negedge clk);
        check("rst_rd_gnt", 64'(gnt), 64'd1);
        step();
        idle_bus();
        rst = 1'b1;
        step();
        req = 1'b1; we = 1'b0; addr = 64'h40;
        @(negedge clk);
        check("midrst_gnt", 64'(gnt), 64'd0);
        check("midrst_rvalid", 64'(rvalid), 64'd0);
        step();
        rst = 1'b0;
        idle_bus();
        late_rv = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            late_rv |= rvalid;
            step();
        end
        check("midrst_no_late_rvalid", 64'(late_rv), 64'd0);
        check("midrst_inflight", 64'(dut.inflight_q), 64'd0);
        single("r_post_rst", 1'b0, 64'h40, 64'h0, 8'hFF, 64'hFEEDFACE01234567, 1'b0);

        for (int k = 0; k < 3; k++) step();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_sram_responder.md
Name: mem_sram_responder

Overview:
- Memory-side slave for the core's generic request/grant/rvalid memory protocol.
- Sits directly downstream of a protocol master (LSU, fetch or testbench driver). Accepts granted requests and backs them with an on-chip word array.
- Returns responses in order after a fixed, parameterised latency, with a configurable cap on in-flight transactions and an external stall input.

Parameters:
- ADDRESS_SIZE, 64: request address width in bits.
- DATA_WIDTH, 64: data width in bits; must be a power of two, at least 8.
- NUM_WORDS, 1024: array depth in words; must be a power of two.
- LATENCY, 2: cycles from grant edge to rvalid; must be at least 1.
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered transactions; range 1..LATENCY.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- address_i  input  ADDRESS_SIZE  byte address.
- data_wdata_i  input  DATA_WIDTH  write data.
- data_req_i  input  1  request valid.
- data_we_i  input  1  1 = write, 0 = read.
- data_be_i  input  DATA_WIDTH/8  byte enables.
- data_gnt_o  output  1  request accepted this cycle.
- data_rvalid_o  output  1  response valid, one cycle per granted request.
- data_rdata_o  output  DATA_WIDTH  read data; 0 for writes and errors.
- data_err_o  output  1  response is for an out-of-range address; qualified by rvalid.
- stall_i  input  1  memory busy; blocks grants.

Behaviour:
- Interface: one clock (clk_i); reset is synchronous and active-high (rst_i).
- Address decode:
  - OFF = log2(DATA_WIDTH/8), IDX = log2(NUM_WORDS).
  - Word index = address_i[OFF +: IDX].
  - A request is in range iff address_i[ADDRESS_SIZE-1 : OFF+IDX] == 0.
  - Low OFF bits are ignored; byte lanes are selected solely by data_be_i.
- Grant, combinational:
  - data_gnt_o = data_req_i & ~stall_i & ~rst_i & (inflight < MAX_OUTSTANDING | data_rvalid_o).
  - A retiring response frees its slot in the same cycle.
  - At most one grant per cycle.
  - data_gnt_o is independent of data_we_i, data_be_i and address_i.
- Handshake: a transaction is accepted on the rising edge where data_req_i & data_gnt_o. The master may change request signals after that edge.
- Write, in range, at grant edge: for each byte b with data_be_i[b]=1, array[idx][8b+7:8b] <= data_wdata_i byte b. Other bytes are unchanged. be = 0 writes nothing but still responds.
- Write, out of range: array is unchanged; response has err=1.
- Read, at grant edge: the array word is sampled into response stage 1 (0 if out of range). Bytes with be=0 still return full-word data.
- Ordering:
  - Array access completes at the grant edge.
  - A read granted in the cycle after a write to the same word returns the new data.
  - Responses are strictly in grant order.
- Response pipeline:
  - LATENCY stages of {valid, err, rdata}; stage 1 is loaded at the grant edge and each stage shifts one per cycle.
  - data_rvalid_o/rdata/err are driven by the last stage.
  - rvalid is high in exactly the cycle LATENCY cycles after the grant edge; for LATENCY=1 that is the cycle immediately after grant.
  - Back-to-back grants give back-to-back rvalids.
  - No response backpressure exists; the master must accept every rvalid.
- inflight counter, width clog2(MAX_OUTSTANDING+1):
  - +1 on grant, −1 on data_rvalid_o.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- stall_i:
  - Forces gnt=0 only; in-flight responses still drain on schedule.
  - Stall may assert or deassert on any cycle.
- Reset values (applied at the clock edge while rst_i=1):
  - All stage valids 0; data_rvalid_o=0; data_rdata_o=0; data_err_o=0; inflight=0.
  - data_gnt_o is 0 while rst_i is high.
  - Array contents are not reset.
- Reset mid-operation: all in-flight responses are discarded and never returned. Writes granted before reset remain committed.
- Request signals while data_req_i=0 are don't-care and have no effect.

Test Plan:
- Reset, then write addr 0x10, wdata 0x1122334455667788, be 0xFF → gnt same cycle; rvalid exactly LATENCY cycles later with rdata=0, err=0. Then read 0x10 → rdata 0x1122334455667788.
- Partial write addr 0x10, be 0x0F, wdata 0xAAAAAAAAAAAAAAAA over 0x1122334455667788, then read → 0x11223344AAAAAAAA. Write with be 0x00 → gnt and rvalid occur, data unchanged.
- LATENCY=3, MAX_OUTSTANDING=2, req held high for 6 cycles:
  - gnt pattern 1,1,0,1,1,0.
  - inflight never exceeds 2.
  - 4 rvalids arrive in grant order.
  - With MAX_OUTSTANDING=3 → 6 consecutive grants and 6 consecutive rvalids.
- Read address with bit ADDRESS_SIZE-1 set → gnt, rvalid with err=1, rdata=0. Out-of-range write to 1<<(OFF+IDX) → err=1, and word 0 is unchanged on readback.
- stall_i high for 4 cycles while req high with 2 transactions in flight → gnt=0 throughout the stall, both rvalids still arrive on schedule, and grants resume on the first cycle with stall_i low.
- rst_i asserted one cycle after a read grant → no rvalid ever appears for that read, inflight=0, gnt=0 during reset; a write granted before reset reads back correctly afterwards.
